// File: rtl/pe_pkg.sv
// pe_pkg: shared state type, default accumulator width and the output
// conversion helper used by psum_accumulator.
// Build option: PSUM_SAT_EN selects saturating conversion in sat_trunc;
// without it the conversion wraps to the low data_w bits.
package pe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_ACC_WIDTH = 32;

  // Working width of sat_trunc; any accumulator up to this width fits.
  localparam int CONV_W = 64;

  // Narrow a sign-extended accumulator to data_w bits. The caller keeps
  // the low data_w bits of the result.
  function automatic logic signed [CONV_W-1:0] sat_trunc(
    input logic signed [CONV_W-1:0] acc,
    input int                       data_w
  );
`ifdef PSUM_SAT_EN
    logic signed [CONV_W-1:0] hi;
    logic signed [CONV_W-1:0] lo;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
`else
    return acc & ((64'sd1 <<< data_w) - 64'sd1);
`endif
  endfunction

endpackage

// File: rtl/psum_adder_tree.sv
// psum_adder_tree: combinational masked sum of the per-row psums. Row r
// contributes its sign-extended value only when r < row_num.
module psum_adder_tree
  import pe_pkg::*;
#(
  parameter  int DATA_WIDTH  = 16,
  parameter  int ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter  int MAX_ROW_NUM = 16,
  localparam int LOG_MRN     = $clog2(MAX_ROW_NUM)
) (
  input  logic        [MAX_ROW_NUM*DATA_WIDTH-1:0] psum,
  input  logic        [LOG_MRN:0]                  row_num,
  output logic signed [ACC_WIDTH-1:0]              sum
);

  // Accumulate the enabled rows; disabled rows add nothing.
  always_comb begin
    sum = '0;
    for (int r = 0; r < MAX_ROW_NUM; r++) begin
      if (r < int'(row_num)) begin
        sum = sum + ACC_WIDTH'($signed(psum[r*DATA_WIDTH +: DATA_WIDTH]));
      end
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// psum_accumulator: PE cluster output stage. Captures one psum per enabled
// row, reduces the rows, accumulates across input channels in an ofmap-row
// buffer and streams finished ofmap values over valid/ready.
// Build option: define PSUM_SAT_EN for saturating output conversion; the
// default build wraps the result to the low DATA_WIDTH bits.
module psum_accumulator
  import pe_pkg::*;
#(
  parameter  int DATA_WIDTH      = 16,
  parameter  int ACC_WIDTH       = DEF_ACC_WIDTH,
  parameter  int MAX_ROW_NUM     = 16,
  parameter  int MAX_OFMAP_WIDTH = 64,
  parameter  int MAX_CHAN_NUM    = 64,
  localparam int LOG_MRN         = $clog2(MAX_ROW_NUM),
  localparam int LOG_MOW         = $clog2(MAX_OFMAP_WIDTH),
  localparam int LOG_MCH         = $clog2(MAX_CHAN_NUM)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_cfg_start,
  input  logic [LOG_MRN:0]                  i_row_num,
  input  logic [LOG_MOW:0]                  i_ofmap_width,
  input  logic [LOG_MCH:0]                  i_chan_num,
  input  logic [MAX_ROW_NUM*DATA_WIDTH-1:0] i_psum_data,
  input  logic [MAX_ROW_NUM-1:0]            i_psum_valid,
  output logic [MAX_ROW_NUM-1:0]            o_row_ready,
  output logic [DATA_WIDTH-1:0]             o_ofmap_data,
  output logic                              o_ofmap_valid,
  input  logic                              i_ofmap_ready,
  output logic                              o_ofmap_last,
  output logic                              o_busy,
  output logic                              o_done
);

  state_t                          state;
  logic [LOG_MRN:0]                row_num;
  logic [LOG_MOW:0]                ofmap_width;
  logic [LOG_MCH:0]                chan_num;
  logic [LOG_MOW-1:0]              col_ptr;
  logic [LOG_MCH-1:0]              chan_cnt;
  logic                            issue_done;

  logic [MAX_ROW_NUM*DATA_WIDTH-1:0] hold;
  logic [MAX_ROW_NUM-1:0]          hold_full;
  logic [MAX_ROW_NUM-1:0]          row_en;
  logic [MAX_ROW_NUM-1:0]          row_hs;

  logic                            cfg_ok;
  logic                            all_full;
  logic                            out_free;
  logic                            s1_adv;
  logic                            reduce;
  logic                            last_col;
  logic                            first_chan;
  logic                            last_chan;

  logic signed [ACC_WIDTH-1:0]     tree_sum;

  logic                            vld_p1;
  logic signed [ACC_WIDTH-1:0]     sum_p1;
  logic [LOG_MOW-1:0]              col_p1;
  logic                            first_p1;
  logic                            lastch_p1;
  logic                            lastcol_p1;

  logic signed [ACC_WIDTH-1:0]     acc_buf [MAX_OFMAP_WIDTH];
  logic signed [ACC_WIDTH-1:0]     acc_base;
  logic signed [ACC_WIDTH-1:0]     acc_new;
  logic signed [CONV_W-1:0]        conv_full;
  logic                            unused_conv_hi;

  assign cfg_ok = (i_row_num != '0) && (int'(i_row_num) <= MAX_ROW_NUM) &&
                  (i_ofmap_width != '0) && (int'(i_ofmap_width) <= MAX_OFMAP_WIDTH) &&
                  (i_chan_num != '0) && (int'(i_chan_num) <= MAX_CHAN_NUM);

  // Enable mask for the rows taking part in this pass.
  always_comb begin
    row_en = '0;
    for (int r = 0; r < MAX_ROW_NUM; r++) begin
      row_en[r] = (r < int'(row_num));
    end
  end

  assign all_full   = &(hold_full | ~row_en);
  assign out_free   = ~o_ofmap_valid | i_ofmap_ready;
  assign s1_adv     = vld_p1 & out_free;
  // Issue a reduction once every enabled row is held and stage 1 can take it;
  // issue_done stops any spare rows from starting a column past the pass.
  assign reduce     = (state == RUN) & ~issue_done & all_full & (~vld_p1 | s1_adv);
  // A full hold that drains this edge may accept its next psum in the same
  // cycle, which keeps the stream at one column per cycle without a stall.
  assign o_row_ready = {MAX_ROW_NUM{state == RUN}} & row_en &
                       (~hold_full | {MAX_ROW_NUM{reduce}});
  assign row_hs     = i_psum_valid & o_row_ready;

  assign last_col   = ({1'b0, col_ptr} == ofmap_width - (LOG_MOW+1)'(1));
  assign first_chan = (chan_cnt == '0);
  assign last_chan  = ({1'b0, chan_cnt} == chan_num - (LOG_MCH+1)'(1));

  assign o_busy = (state != IDLE);
  assign o_done = (state == DONE);

  psum_adder_tree #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ACC_WIDTH   (ACC_WIDTH),
    .MAX_ROW_NUM (MAX_ROW_NUM)
  ) u_tree (
    .psum    (hold),
    .row_num (row_num),
    .sum     (tree_sum)
  );

  // Stage 2 read-modify-write operand: the first channel starts from zero.
  assign acc_base  = first_p1 ? '0 : acc_buf[col_p1];
  assign acc_new   = acc_base + sum_p1;
  assign conv_full = sat_trunc(CONV_W'(acc_new), DATA_WIDTH);
  assign unused_conv_hi = ^conv_full[CONV_W-1:DATA_WIDTH];

  // Control: FSM, config, column/channel counters, hold flags, pipeline valids, output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      row_num       <= '0;
      ofmap_width   <= '0;
      chan_num      <= '0;
      col_ptr       <= '0;
      chan_cnt      <= '0;
      issue_done    <= 1'b0;
      hold_full     <= '0;
      vld_p1        <= 1'b0;
      o_ofmap_valid <= 1'b0;
      o_ofmap_last  <= 1'b0;
      o_ofmap_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_cfg_start && cfg_ok) begin
            state       <= RUN;
            row_num     <= i_row_num;
            ofmap_width <= i_ofmap_width;
            chan_num    <= i_chan_num;
            col_ptr     <= '0;
            chan_cnt    <= '0;
            issue_done  <= 1'b0;
          end
        end
        RUN: begin
          if (o_ofmap_valid && i_ofmap_ready && o_ofmap_last) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (reduce) begin
        if (last_col) begin
          col_ptr  <= '0;
          chan_cnt <= chan_cnt + 1'b1;
          if (last_chan) issue_done <= 1'b1;
        end else begin
          col_ptr <= col_ptr + 1'b1;
        end
      end

      if (state != RUN) hold_full <= '0;
      else              hold_full <= (reduce ? '0 : hold_full) | row_hs;

      if (reduce)      vld_p1 <= 1'b1;
      else if (s1_adv) vld_p1 <= 1'b0;

      if (s1_adv && lastch_p1) begin
        o_ofmap_valid <= 1'b1;
        o_ofmap_data  <= conv_full[DATA_WIDTH-1:0];
        o_ofmap_last  <= lastcol_p1;
      end else if (i_ofmap_ready) begin
        o_ofmap_valid <= 1'b0;
      end
    end
  end

  // Stage 0 -> 1: row capture into the holds and reduction into stage 1.
  always_ff @(posedge clk) begin
    for (int r = 0; r < MAX_ROW_NUM; r++) begin
      if (row_hs[r]) hold[r*DATA_WIDTH +: DATA_WIDTH] <= i_psum_data[r*DATA_WIDTH +: DATA_WIDTH];
    end
    if (reduce) begin
      sum_p1     <= tree_sum;
      col_p1     <= col_ptr;
      first_p1   <= first_chan;
      lastch_p1  <= last_chan;
      lastcol_p1 <= last_col;
    end
  end

  // Stage 1 -> 2: non-final channels accumulate into the ofmap-row buffer.
  always_ff @(posedge clk) begin
    if (s1_adv && !lastch_p1) acc_buf[col_p1] <= acc_new;
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: scoreboard bench for psum_accumulator. Expected ofmap
// values come from a plain-arithmetic model over a psum table; a monitor
// pops and compares every output handshake.
module tb_psum_accumulator;

  localparam int DW = 16;
  localparam int NR = 16;
  localparam int P_RAND  = 0;
  localparam int P_CONST = 1;
  localparam int P_BASIC = 2;
  localparam int P_STAG  = 4;
  localparam int P_REUSE = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cfg_start = 1'b0;
  logic [4:0]        row_num_i = '0;
  logic [6:0]        ofw_i = '0;
  logic [6:0]        chn_i = '0;
  logic [NR*DW-1:0]  psum_data = '0;
  logic [NR-1:0]     psum_valid = '0;
  logic [NR-1:0]     row_ready;
  logic [DW-1:0]     ofmap_data;
  logic              ofmap_valid;
  logic              ofmap_ready = 1'b1;
  logic              ofmap_last;
  logic              busy;
  logic              done;

  psum_accumulator dut (
    .clk           (clk),
    .reset         (reset),
    .i_cfg_start   (cfg_start),
    .i_row_num     (row_num_i),
    .i_ofmap_width (ofw_i),
    .i_chan_num    (chn_i),
    .i_psum_data   (psum_data),
    .i_psum_valid  (psum_valid),
    .o_row_ready   (row_ready),
    .o_ofmap_data  (ofmap_data),
    .o_ofmap_valid (ofmap_valid),
    .i_ofmap_ready (ofmap_ready),
    .o_ofmap_last  (ofmap_last),
    .o_busy        (busy),
    .o_done        (done)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          last;
  } exp_t;

  exp_t              exp_q[$];
  logic signed [15:0] pv [64][64][NR];
  int                tests = 0;
  int                fails = 0;
  int                cyc = 0;
  int                last_hs_cyc = 0;
  int                rdy_mode = 0;
  int                stall_left = 0;
  bit                stalled_once = 0;
  bit                saw_low = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference conversion of a full-precision column sum to the output width.
  function automatic logic [DW-1:0] model_conv(input longint s);
    logic [63:0] t;
`ifdef PSUM_SAT_EN
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
`endif
    t = s;
    return t[DW-1:0];
  endfunction

  // Output ready generator: always, random, or a single 5-cycle stall.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: ofmap_ready = 1'b1;
        1: ofmap_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (!stalled_once && ofmap_valid) begin
            stalled_once = 1;
            stall_left = 5;
          end
          if (stall_left > 0) begin
            ofmap_ready = 1'b0;
            stall_left--;
          end else begin
            ofmap_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor: compares handshaked outputs against the scoreboard and checks
  // that a stalled output holds steady.
  initial begin
    exp_t          e;
    bit            held = 0;
    logic [DW-1:0] held_d = '0;
    logic          held_l = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        held = 0;
      end else begin
        if (held) begin
          check("stall_valid", ofmap_valid, 1);
          check("stall_data", ofmap_data, held_d);
          check("stall_last", ofmap_last, held_l);
        end
        held = 0;
        if (ofmap_valid) begin
          if (ofmap_ready) begin
            if (exp_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_out: got %0d expected no output", ofmap_data);
            end else begin
              e = exp_q.pop_front();
              check("ofmap_data", ofmap_data, e.d);
              check("ofmap_last", ofmap_last, e.last);
              if (e.last) last_hs_cyc = cyc;
            end
          end else begin
            held = 1;
            held_d = ofmap_data;
            held_l = ofmap_last;
          end
        end
        if (rdy_mode == 2 && !ofmap_ready && ofmap_valid && row_ready == '0) saw_low = 1;
      end
    end
  end

  task automatic start_cfg(input int rows, input int width, input int chan, input bit expect_start);
    @(negedge clk);
    row_num_i = 5'(rows);
    ofw_i     = 7'(width);
    chn_i     = 7'(chan);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    check("busy_after_cfg", busy, expect_start);
  endtask

  // One pass: build the psum table, push expected outputs, stream the rows
  // (staggered/gapped), optionally wait for completion and check o_done.
  task automatic run_pass(input int rows, input int width, input int chan, input int pat,
                          input int cval, input int limit, input int gapmax, input int stag,
                          input bit garb, input bit wait_out);
    int  n;
    int  idx[NR];
    int  gap[NR];
    bit  pend[NR];
    bit  fin;
    int  guard;
    bit  got;
    exp_t e;
    longint s;
    if (pat != P_REUSE) begin
      for (int ch = 0; ch < chan; ch++)
        for (int c = 0; c < width; c++)
          for (int r = 0; r < NR; r++)
            case (pat)
              P_RAND:  pv[ch][c][r] = 16'($urandom);
              P_BASIC: pv[ch][c][r] = 16'(10 * r + c + 1);
              P_STAG:  pv[ch][c][r] = 16'(7 + r);
              default: pv[ch][c][r] = 16'(cval);
            endcase
    end
    n = (limit >= 0) ? limit : width * chan;
    if (limit < 0) begin
      for (int c = 0; c < width; c++) begin
        s = 0;
        for (int ch = 0; ch < chan; ch++)
          for (int r = 0; r < rows; r++) s += longint'(pv[ch][c][r]);
        e.d = model_conv(s);
        e.last = (c == width - 1);
        exp_q.push_back(e);
      end
    end
    start_cfg(rows, width, chan, 1);
    for (int r = 0; r < NR; r++) begin
      idx[r] = 0;
      gap[r] = r * stag;
      pend[r] = 0;
    end
    fin = 0;
    guard = 0;
    while (!fin) begin
      @(negedge clk);
      guard++;
      fin = 1;
      for (int r = 0; r < NR; r++) begin
        if (r < rows) begin
          if (pend[r]) begin
            idx[r]++;
            psum_valid[r] = 1'b0;
            pend[r] = 0;
            gap[r] = $urandom_range(0, gapmax);
          end
          if (!psum_valid[r] && idx[r] < n) begin
            if (gap[r] > 0) gap[r]--;
            else begin
              psum_valid[r] = 1'b1;
              psum_data[r*DW +: DW] = pv[idx[r] / width][idx[r] % width][r];
            end
          end
          pend[r] = psum_valid[r] && row_ready[r];
          if (idx[r] < n) fin = 0;
        end else if (garb) begin
          psum_valid[r] = 1'($urandom_range(0, 1));
          psum_data[r*DW +: DW] = 16'h1234;
        end else begin
          psum_valid[r] = 1'b0;
        end
      end
      if (guard > 20000) begin
        tests++;
        fails++;
        $display("FAIL drive_timeout: got %0d cycles expected at most 20000", guard);
        fin = 1;
      end
    end
    psum_valid = '0;
    if (wait_out) begin
      got = 0;
      for (int i = 0; i < 5000 && !got; i++) begin
        @(negedge clk);
        if (done) got = 1;
      end
      check("done_seen", got, 1);
      if (got) begin
        check("done_latency", cyc - last_hs_cyc, 1);
        check("sb_empty", exp_q.size(), 0);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("busy_idle", busy, 0);
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", ofmap_valid, 0);
    check("rst_data", ofmap_data, 0);
    check("rst_last", ofmap_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", row_ready, 0);
    reset = 1'b1;

    // Out-of-range configurations are ignored
    start_cfg(0, 4, 1, 0);
    start_cfg(17, 4, 1, 0);
    start_cfg(3, 65, 1, 0);
    start_cfg(3, 4, 0, 0);
    start_cfg(3, 4, 65, 0);

    // Basic reduction: 33, 36, 39, 42
    run_pass(3, 4, 1, P_BASIC, 0, -1, 0, 0, 0, 1);

    // Channel accumulation: 30, 30
    run_pass(2, 2, 3, P_CONST, 5, -1, 0, 0, 0, 1);

    // Stagger and disabled rows, with psum valids pulsed while idle
    @(negedge clk);
    psum_valid = '1;
    psum_data = {NR{16'h1234}};
    repeat (3) @(negedge clk);
    psum_valid = '0;
    run_pass(2, 1, 1, P_STAG, 0, -1, 0, 3, 1, 1);

    // Backpressure: stall 5 cycles, then the same data unstalled
    rdy_mode = 2;
    stalled_once = 0;
    saw_low = 0;
    run_pass(4, 8, 2, P_RAND, 0, -1, 0, 0, 0, 1);
    check("row_ready_dropped", saw_low, 1);
    rdy_mode = 0;
    run_pass(4, 8, 2, P_REUSE, 0, -1, 0, 0, 0, 1);

    // Conversion boundaries
    run_pass(16, 2, 1, P_CONST, 32767, -1, 0, 0, 0, 1);
    run_pass(16, 2, 1, P_CONST, -32768, -1, 0, 0, 0, 1);

    // Single-column back-to-back accumulation
    run_pass(5, 1, 4, P_RAND, 0, -1, 0, 0, 0, 1);

    // Randomised passes with random output backpressure
    rdy_mode = 1;
    for (int t = 0; t < 6; t++) begin
      run_pass($urandom_range(1, 16), $urandom_range(1, 6), $urandom_range(1, 4),
               P_RAND, 0, -1, 2, $urandom_range(0, 2), 1, 1);
    end
    rdy_mode = 0;

    // Reset during channel 1, then a clean single-channel rerun
    run_pass(2, 4, 3, P_RAND, 0, 6, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", ofmap_valid, 0);
    check("mid_rst_data", ofmap_data, 0);
    check("mid_rst_last", ofmap_last, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_ready", row_ready, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    run_pass(2, 4, 1, P_CONST, 1, -1, 0, 0, 0, 1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
